// File: rtl/rv_pkg.sv
// Shared RV execution-unit definitions: datapath width and M-extension
// divide op encodings used by decode, the multiplier and the divider.
package rv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    function automatic logic div_op_is_signed(input div_op_e o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic div_op_is_rem(input div_op_e o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider: one shift-subtract per cycle over XLEN cycles,
// with divide-by-zero and signed overflow resolved in a single cycle.
module div_unit #(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import rv_pkg::*;

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_result;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_is_rem;
    logic            r_busy;
    logic            r_done;

    div_op_e         w_op;
    logic            w_signed;
    logic            w_div0;
    logic            w_ovf;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_special;

    assign w_op      = div_op_e'(op);
    assign w_signed  = div_op_is_signed(w_op);
    assign w_div0    = (b == '0);
    assign w_ovf     = w_signed && (a == MIN_NEG) && (b == '1);
    assign w_a_neg   = w_signed && a[XLEN-1];
    assign w_b_neg   = w_signed && b[XLEN-1];
    assign w_a_mag   = w_a_neg ? -a : a;
    assign w_b_mag   = w_b_neg ? -b : b;
    assign w_special = div_op_is_rem(w_op) ? (w_div0 ? a : '0)
                                           : (w_div0 ? '1 : MIN_NEG);

    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_bit;
    logic [XLEN-1:0] w_rem_new;
    logic [XLEN-1:0] w_quo_new;
    logic [XLEN-1:0] w_ndiff;
    logic [XLEN-1:0] w_nrem_sh;
    logic [XLEN-2:0] w_qp_neg;
    logic [XLEN-1:0] w_rem_fin;
    logic [XLEN-1:0] w_quo_fin;

    assign w_rem_sh  = {r_rem, r_dvd[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_bit     = ~w_diff[XLEN];
    assign w_rem_new = w_bit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_new = {r_quo[XLEN-2:0], w_bit};

    // Sign correction is folded into the last step with parallel adders so the
    // critical path stays a single subtract: -(2q+1) = {~q,1}, -(2q) = {-q,0}.
    assign w_ndiff   = r_dvs - w_rem_sh[XLEN-1:0];
    assign w_nrem_sh = -w_rem_sh[XLEN-1:0];
    assign w_qp_neg  = -r_quo[XLEN-2:0];
    assign w_rem_fin = r_neg_r ? (w_bit ? w_ndiff : w_nrem_sh) : w_rem_new;
    assign w_quo_fin = r_neg_q ? (w_bit ? {~r_quo[XLEN-2:0], 1'b1} : {w_qp_neg, 1'b0})
                               : w_quo_new;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_is_rem <= div_op_is_rem(w_op);
                        if (w_div0 || w_ovf) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_special;
                        end else begin
                            r_state <= S_CALC;
                            r_dvd   <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_rem   <= '0;
                            r_quo   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
                        r_rem <= w_rem_new;
                        r_quo <= w_quo_new;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(XLEN-1)) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= r_is_rem ? w_rem_fin : w_quo_fin;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a divide; accepted only in IDLE.
REQ-005 SHALL have port op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port a  input  32  dividend, sourced from register-file read port 1.
REQ-007 SHALL have port b  input  32  divisor, sourced from register-file read port 2.
REQ-008 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  single-cycle pulse; result valid.
REQ-011 SHALL have port result  output  32  quotient or remainder, held until the next accepted start.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 SHALL accept start only when in IDLE with flush low; at acceptance, latch op, a and b, and ignore later input changes.
REQ-014 SHALL ignore start while busy; no queuing.
REQ-015 SHALL go IDLE->DONE directly (done at cycle 1 after the acceptance edge) for special cases: b==0, or signed op with a==0x80000000 and b==0xFFFFFFFF.
REQ-016 SHALL go IDLE->CALC for all other cases, and run exactly 32 restoring shift-subtract iterations, one per cycle, counted by a 5-bit counter.
REQ-017 SHALL go CALC->DONE after the 32nd iteration, so that done is asserted in cycle 33 after the acceptance edge.
REQ-018 SHALL go DONE->IDLE unconditionally after one cycle; a start in the DONE cycle is ignored.
REQ-019 SHALL, for signed ops, divide magnitudes; quotient negated iff the signs of a and b differ and b!=0; remainder takes the sign of a.
REQ-020 SHALL produce, on divide-by-zero: quotient 0xFFFFFFFF (DIV and DIVU); remainder = a (REM and REMU).
REQ-021 SHALL produce, on signed overflow (0x80000000 / -1): quotient 0x80000000; remainder 0.
REQ-022 SHALL select the remainder for REM/REMU and the quotient otherwise; result updates only on entry to DONE.
REQ-023 SHALL, with flush high in CALC or DONE, enter IDLE next edge, with no done pulse and result unchanged.
REQ-024 SHALL, with flush and start both high in IDLE, let flush win; start is not accepted.
REQ-025 SHALL keep the datapath combinational depth to one 33-bit subtract per cycle.

Reset
REQ-026 SHALL, on rst asserted, immediately (asynchronously) force: state IDLE, busy 0, done 0, result 0, counter 0, internal operand/remainder/quotient registers 0.
REQ-027 SHALL, when rst is asserted mid-CALC, abort the operation; no done follows reset release.
REQ-028 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-029 SHALL take op encodings (DIV/DIVU/REM/REMU) and XLEN from the shared package rv_pkg, for reuse by decode and the multiplier.
REQ-030 SHALL hold the FSM state encoding local to div_unit; it is not exported.
REQ-031 SHALL be a single module; no sub-module, since the iteration step is one subtract-and-shift.

Verification
REQ-032 SHALL cover: DIV a=100 b=0xFFFFFFF9 (-7) -> done at cycle 33, result 0xFFFFFFF2 (-14); REM with the same operands -> 2.
REQ-033 SHALL cover: DIVU a=0xFFFFFFFF b=2 -> result 0x7FFFFFFF at cycle 33; REMU with the same operands -> 1.
REQ-034 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF at cycle 1; REM 5/0 -> 5 at cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM with the same operands -> 0.
REQ-035 SHALL cover: a start pulse at cycle 10 of an in-flight op is ignored; the original op completes at cycle 33 with its own result.
REQ-036 SHALL cover: flush at cycle 10 -> busy 0 at cycle 11, no done, result retains its prior value; a new DIVU 9/3 then yields 3.
REQ-037 SHALL cover: rst asserted mid-CALC between clock edges -> busy, done and result are 0 immediately; a new op after release completes normally.
